gpr_mp: RTL

Parametrised multi-port general purpose register file, the next-generation GPR for the core.
- Configurable data width, register count, read-port count and write-port count.
- Write-to-read forwarding across all write ports.
- Per-register busy scoreboard: set at issue, cleared at writeback. The decode/issue stage uses it to stall on RAW hazards.
- Sits at the WB stage. Read side feeds ID.

---
 rtl/gpr_mp_pkg.sv | 17 +
 rtl/gpr_rd_port.sv | 67 ++++++
 rtl/gpr_mp.sv | 116 +++++++++++
 3 files changed

// File: rtl/gpr_mp_pkg.sv
// gpr_mp_pkg
// Shared constants for the multi-port general purpose register file.
//   RstEnable   : level of n_rst_i that holds the block in reset
//   WriteEnable : active level of a write-port enable
//   ReadEnable  : active level of a read-port enable
//   ZeroWord    : value returned for x0 / disabled reads
//   DEF_DATA_W, DEF_REG_NUM : default register width and register count
// Optional feature macro: GPR_PARITY_EN (per-entry even parity with a
// sticky error flag).
package gpr_mp_pkg;
  localparam logic RstEnable   = 1'b0;
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;
  localparam int   DEF_DATA_W  = 32;
  localparam int   DEF_REG_NUM = 32;
  localparam logic [DEF_DATA_W-1:0] ZeroWord = '0;
endpackage

// File: rtl/gpr_rd_port.sv
// gpr_rd_port
// One combinational read port of the register file: x0/enable masking,
// write-to-read forwarding from every write port (highest index wins),
// and the busy lookup for the addressed register.
// Ports:
//   n_rst_i            reset level; outputs forced to 0 while low
//   re_i, raddr_i      read enable and address
//   we_i/waddr_i/wdata_i  all write ports, flattened
//   issue_i/issue_rd_i same-cycle issue (keeps busy visible under forwarding)
//   arr_data_i/arr_busy_i  array entry and busy bit at raddr_i
//   arr_par_i/par_bad_o    stored parity / parity mismatch (GPR_PARITY_EN)
//   rdata_o/rbusy_o    read data and busy flag
// Optional feature macro: GPR_PARITY_EN.
module gpr_rd_port
  import gpr_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = 5,
  parameter int NUM_WR = 2
) (
  input  logic                     n_rst_i,
  input  logic                     re_i,
  input  logic [ADDR_W-1:0]        raddr_i,
  input  logic [NUM_WR-1:0]        we_i,
  input  logic [NUM_WR*ADDR_W-1:0] waddr_i,
  input  logic [NUM_WR*DATA_W-1:0] wdata_i,
  input  logic                     issue_i,
  input  logic [ADDR_W-1:0]        issue_rd_i,
  input  logic [DATA_W-1:0]        arr_data_i,
  input  logic                     arr_busy_i,
`ifdef GPR_PARITY_EN
  input  logic                     arr_par_i,
  output logic                     par_bad_o,
`endif
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     rbusy_o
);
  logic              active;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign active = (n_rst_i != RstEnable) && (re_i == ReadEnable) && (raddr_i != '0);

  // Ascending scan so the highest matching write port overrides lower ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = DATA_W'(ZeroWord);
    for (int k = 0; k < NUM_WR; k++) begin
      if (we_i[k] == WriteEnable && waddr_i[k*ADDR_W +: ADDR_W] == raddr_i) begin
        fwd_hit  = 1'b1;
        fwd_data = wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign rdata_o = !active ? DATA_W'(ZeroWord) : (fwd_hit ? fwd_data : arr_data_i);

  // A forwarded writeback retires the pending producer, unless a new
  // producer for the same register is issued in the same cycle.
  assign rbusy_o = active && arr_busy_i &&
                   (!fwd_hit || (issue_i && issue_rd_i == raddr_i));

`ifdef GPR_PARITY_EN
  // Only data actually taken from the array is checked.
  assign par_bad_o = active && !fwd_hit && ((^arr_data_i) != arr_par_i);
`endif
endmodule

// File: rtl/gpr_mp.sv
// gpr_mp
// Parametrised multi-port GPR with write-to-read forwarding and a
// per-register busy scoreboard for RAW hazard stalls.
// Ports:
//   clk_i, n_rst_i          clock, asynchronous active-low reset
//   we_i/waddr_i/wdata_i    NUM_WR write ports (port k at slice k)
//   issue_i/issue_rd_i      destination register issued this cycle
//   re_i/raddr_i            NUM_RD read ports
//   rdata_o/rbusy_o         combinational read data and busy flags
//   par_err_o               sticky parity error (GPR_PARITY_EN only)
// Optional feature macro: GPR_PARITY_EN.
module gpr_mp
  import gpr_mp_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_NUM = DEF_REG_NUM,
  parameter int ADDR_W  = $clog2(REG_NUM),
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 2
) (
  input  logic                     clk_i,
  input  logic                     n_rst_i,
  input  logic [NUM_WR-1:0]        we_i,
  input  logic [NUM_WR*ADDR_W-1:0] waddr_i,
  input  logic [NUM_WR*DATA_W-1:0] wdata_i,
  input  logic                     issue_i,
  input  logic [ADDR_W-1:0]        issue_rd_i,
  input  logic [NUM_RD-1:0]        re_i,
  input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
  output logic [NUM_RD*DATA_W-1:0] rdata_o,
  output logic [NUM_RD-1:0]        rbusy_o
`ifdef GPR_PARITY_EN
  ,
  output logic                     par_err_o
`endif
);
  logic [DATA_W-1:0]  regs_q [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;

  // Writeback clears, issue sets afterwards so a same-cycle issue wins.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (we_i[k] == WriteEnable) busy_d[waddr_i[k*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (issue_i) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Later loop iterations override earlier ones: higher write port wins.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (n_rst_i == RstEnable) begin
      busy_q <= '0;
      for (int r = 0; r < REG_NUM; r++) regs_q[r] <= '0;
    end else begin
      busy_q <= busy_d;
      for (int k = 0; k < NUM_WR; k++) begin
        if (we_i[k] == WriteEnable && waddr_i[k*ADDR_W +: ADDR_W] != '0)
          regs_q[waddr_i[k*ADDR_W +: ADDR_W]] <= wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef GPR_PARITY_EN
  logic [REG_NUM-1:0] par_q;
  logic [NUM_RD-1:0]  par_bad;
  logic               par_err_q;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (n_rst_i == RstEnable) begin
      par_q     <= '0;
      par_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (we_i[k] == WriteEnable && waddr_i[k*ADDR_W +: ADDR_W] != '0)
          par_q[waddr_i[k*ADDR_W +: ADDR_W]] <= ^wdata_i[k*DATA_W +: DATA_W];
      end
      par_err_q <= par_err_q | (|par_bad);
    end
  end

  assign par_err_o = par_err_q;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = raddr_i[gi*ADDR_W +: ADDR_W];

      gpr_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR)
      ) u_rd (
        .n_rst_i    (n_rst_i),
        .re_i       (re_i[gi]),
        .raddr_i    (ra),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .issue_i    (issue_i),
        .issue_rd_i (issue_rd_i),
        .arr_data_i (regs_q[ra]),
        .arr_busy_i (busy_q[ra]),
`ifdef GPR_PARITY_EN
        .arr_par_i  (par_q[ra]),
        .par_bad_o  (par_bad[gi]),
`endif
        .rdata_o    (rdata_o[gi*DATA_W +: DATA_W]),
        .rbusy_o    (rbusy_o[gi])
      );
    end
  endgenerate
endmodule
